// File: rtl/decoder_3to8_pkg.sv
// Shared constants and types for the registered 3-to-8 decoder.
//   DEC_SEL_W : select width (3 bits, {a,b,c})
//   DEC_OUT_N : number of one-hot outputs (8)
package decoder_3to8_pkg;

    localparam int unsigned DEC_SEL_W = 3;
    localparam int unsigned DEC_OUT_N = 8;

    typedef logic [DEC_SEL_W-1:0] dec_sel_t;
    typedef logic [DEC_OUT_N-1:0] dec_vec_t;

endpackage : decoder_3to8_pkg

// File: rtl/decoder_3to8_core.sv
// Combinational select-to-one-hot map, gated by enable.
// Ports:
//   i_sel      : 3-bit select, unsigned 0..7
//   i_en       : enable; when low the vector is all zero
//   o_onehot_c : 8-bit one-hot vector, bit N set when i_sel == N
module decoder_3to8_core
    import decoder_3to8_pkg::*;
(
    input  logic [DEC_SEL_W-1:0] i_sel,
    input  logic                 i_en,
    output logic [DEC_OUT_N-1:0] o_onehot_c
);

    // One bit per select value; all zero when disabled.
    always_comb begin
        o_onehot_c = '0;
        for (int unsigned n = 0; n < DEC_OUT_N; n++) begin
            if (i_en && (i_sel == DEC_SEL_W'(n))) begin
                o_onehot_c[n] = 1'b1;
            end
        end
    end

endmodule : decoder_3to8_core

// File: rtl/decoder_3to8.sv
// Registered 3-to-8 decoder: one-cycle latency from {a,b,c}/en to y0..y7/vld.
// Ports:
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset, priority over en
//   en         : decode enable
//   a, b, c    : select bits, a is MSB
//   y0..y7     : registered one-hot outputs, yN set for select value N
//   vld        : registered; high when y holds a decode of an enabled sample
module decoder_3to8
    import decoder_3to8_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y0,
    output logic y1,
    output logic y2,
    output logic y3,
    output logic y4,
    output logic y5,
    output logic y6,
    output logic y7,
    output logic vld
);

    dec_sel_t w_sel;
    dec_vec_t w_onehot;
    dec_vec_t r_y;
    logic     r_vld;

    assign w_sel = {a, b, c};

    decoder_3to8_core u_core (
        .i_sel      (w_sel),
        .i_en       (en),
        .o_onehot_c (w_onehot)
    );

    // Output register; a disabled sample clears rather than holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_y   <= w_onehot;
            r_vld <= en;
        end
    end

    assign y0  = r_y[0];
    assign y1  = r_y[1];
    assign y2  = r_y[2];
    assign y3  = r_y[3];
    assign y4  = r_y[4];
    assign y5  = r_y[5];
    assign y6  = r_y[6];
    assign y7  = r_y[7];
    assign vld = r_vld;

endmodule : decoder_3to8

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: directed steps plus a random run
// against a one-cycle-delayed behavioural model.
module tb_decoder_3to8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic a   = 1'b0;
    logic b   = 1'b0;
    logic c   = 1'b0;
    logic y0, y1, y2, y3, y4, y5, y6, y7, vld;

    int tests = 0;
    int fails = 0;

    // Model state: what the outputs must show after the latest edge.
    logic [7:0] exp_y   = 8'h00;
    logic       exp_vld = 1'b0;

    always #5 clk = ~clk;

    decoder_3to8 dut (
        .clk (clk), .rst (rst), .en (en),
        .a (a), .b (b), .c (c),
        .y0 (y0), .y1 (y1), .y2 (y2), .y3 (y3),
        .y4 (y4), .y5 (y5), .y6 (y6), .y7 (y7),
        .vld (vld)
    );

    function automatic logic [7:0] y_vec();
        return {y7, y6, y5, y4, y3, y2, y1, y0};
    endfunction

    task automatic check(input string tag);
        logic [7:0] got;
        got = y_vec();
        tests++;
        assert (got === exp_y) else begin
            fails++;
            $error("FAIL %s y: got %b expected %b", tag, got, exp_y);
        end
        tests++;
        assert (vld === exp_vld) else begin
            fails++;
            $error("FAIL %s vld: got %b expected %b", tag, vld, exp_vld);
        end
        // Invariant: vld -> exactly one y high; !vld -> all y low.
        tests++;
        assert ((vld === 1'b1) ? ($countones(got) == 1) : (got === 8'h00)) else begin
            fails++;
            $error("FAIL %s onehot: got y=%b vld=%b expected one-hot iff vld", tag, got, vld);
        end
    endtask

    // Apply inputs just after an edge, confirm outputs did not move
    // combinationally, then clock once and check against the model.
    task automatic step(input logic r, input logic e, input int unsigned sel, input string tag);
        rst = r;
        en  = e;
        {a, b, c} = 3'(sel);
        #1;
        check({tag, "/pre"});
        @(posedge clk);
        if (r) begin
            exp_y   = 8'h00;
            exp_vld = 1'b0;
        end else if (e) begin
            exp_y   = 8'(2 ** sel);
            exp_vld = 1'b1;
        end else begin
            exp_y   = 8'h00;
            exp_vld = 1'b0;
        end
        #1;
        check(tag);
    endtask

    initial begin
        // Reset with en=1, abc=101 for two cycles.
        rst = 1'b1; en = 1'b1; {a, b, c} = 3'b101;
        @(posedge clk); #1;
        step(1'b1, 1'b1, 5, "reset1");
        step(1'b1, 1'b1, 5, "reset2");

        // Sweep 0..7 back to back.
        for (int unsigned s = 0; s < 8; s++) begin
            step(1'b0, 1'b1, s, $sformatf("sweep%0d", s));
        end

        // Disable then re-enable.
        step(1'b0, 1'b1, 3, "dis_y3");
        step(1'b0, 1'b0, 3, "dis_off");
        step(1'b0, 1'b1, 6, "dis_y6");

        // Mid-stream reset during a sweep.
        for (int unsigned s = 0; s < 4; s++) begin
            step(1'b0, 1'b1, s, $sformatf("mid%0d", s));
        end
        step(1'b1, 1'b1, 4, "mid_rst");
        step(1'b0, 1'b1, 7, "mid_y7");

        // Random run with occasional reset.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 3) != 0),
                 $urandom_range(0, 7),
                 $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_decoder_3to8
